kamacore_stage_id: RTL
======================

KAMACORE_STAGE_ID -- requirements
Module: kamacore_stage_id

Interface
REQ-001 Parameter CPU_WIDTH, default 32 (from package), datapath and instruction width.
REQ-002 Parameter REG_COUNT, default 32 (from package), number of architectural registers; index width REG_IDX_W = 5.
REQ-003 Port clk  input  1  clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port if_instr  input  CPU_WIDTH  instruction registered by fetch stage.
REQ-006 Port if_valid  input  1  if_instr holds a real instruction.
REQ-007 Port flush  input  1  branch taken; discard instruction currently in decode.
REQ-008 Port stall  output  1  combinational; fetch SHALL hold PC and if_instr while high.
REQ-009 Port wb_we / wb_rd / wb_data  input  1 / REG_IDX_W / CPU_WIDTH  register write-back port.
REQ-010 Port ex_valid  output  1  ID/EX register holds a live instruction.
REQ-011 Port ex_opcode / ex_rd  output  6 / REG_IDX_W  decoded opcode and destination.
REQ-012 Port ex_rs1_val / ex_rs2_val / ex_imm  output  CPU_WIDTH each  operand values, sign-extended immediate.
REQ-013 Port ex_is_load / ex_illegal  output  1 each  load marker; one-cycle illegal-opcode flag.

Function
REQ-014 Field layout: opcode [31:26], rd [25:21], rs1 [20:16], rs2 [15:11], imm [15:0].
REQ-015 Opcodes: NOP=0, ALU=1, ALUI=2, LOAD=3, STORE=4, BRANCH=5; rs2 used only by ALU, STORE, BRANCH.
REQ-016 ex_imm = imm sign-extended from bit 15 to CPU_WIDTH.
REQ-017 Register x0 reads 0 always; writes to x0 ignored.
REQ-018 Register file: 2 combinational read ports, 1 synchronous write port.
REQ-019 Write-through: if wb_we and wb_rd == rsN and rsN != 0, operand N takes wb_data in the same cycle.
REQ-020 Load-use hazard: stall = ex_valid & ex_is_load & ex_rd != 0 & (ex_rd == rs1 | (rs2 used & ex_rd == rs2)) & if_valid & !flush.
REQ-021 On stall: ID/EX loads a bubble (ex_valid=0, all other ex_* fields 0); decode input is re-presented next cycle.
REQ-022 On flush: ID/EX loads a bubble and stall = 0; flush overrides stall in the same cycle.
REQ-023 Otherwise ID/EX captures the decode of if_instr; ex_valid = if_valid & opcode legal & opcode != NOP.
REQ-024 Opcode > 5 with if_valid: ex_illegal = 1 for exactly one cycle, ex_valid = 0.
REQ-025 Latency: one cycle from if_instr to ex_* outputs; no stall is ever longer than one cycle per load.
REQ-026 Writes to the register file proceed during stall and flush.

Reset
REQ-027 While rst is high, all ex_* outputs are 0 and stall is 0.
REQ-028 Register file contents are cleared to 0 on rst.
REQ-029 Reset mid-stall: the bubble is discarded, and decode resumes on the first edge after rst deasserts.

Structure
REQ-030 CPU_WIDTH, REG_COUNT, REG_IDX_W, opcode enum and field-position constants live in kamacore_pkg.
REQ-031 One sub-module, kamacore_regfile (2R1W, x0 hardwired, reset-clearable), is instantiated; hazard and decode logic are inline.

Verification
REQ-032 Write x3=0x1234 via WB, then decode ALU rd=4, rs1=3, rs2=0 -> next cycle ex_rs1_val=0x1234, ex_rs2_val=0.
REQ-033 wb_we with rd=5, data=0xAA in the same cycle as decode of rs1=5 -> ex_rs1_val=0xAA (bypass).
REQ-034 LOAD rd=6, then ALU rs2=6 -> stall=1 for one cycle, one bubble, ALU appears in EX on the following cycle.
REQ-035 LOAD rd=6, then ALUI rs1=0, rs2 field=6 -> no stall (rs2 unused).
REQ-036 Hazard pair with flush asserted on the stall cycle -> stall=0, ex_valid=0 next cycle.
REQ-037 Opcode 0x3F, then ALUI imm=0x8000 -> ex_illegal pulse of one cycle; ex_imm=0xFFFF8000; rst mid-stream -> all ex_* = 0.

Source files
------------

// File: rtl/kamacore_pkg.sv
// Shared constants, opcode encoding and field positions for the kamacore pipeline.
package kamacore_pkg;

    localparam int unsigned CPU_WIDTH = 32;
    localparam int unsigned REG_COUNT = 32;
    localparam int unsigned REG_IDX_W = 5;

    localparam int unsigned OPC_MSB = 31;
    localparam int unsigned OPC_LSB = 26;
    localparam int unsigned RD_MSB  = 25;
    localparam int unsigned RD_LSB  = 21;
    localparam int unsigned RS1_MSB = 20;
    localparam int unsigned RS1_LSB = 16;
    localparam int unsigned RS2_MSB = 15;
    localparam int unsigned RS2_LSB = 11;
    localparam int unsigned IMM_MSB = 15;
    localparam int unsigned IMM_LSB = 0;

    typedef enum logic [5:0] {
        OP_NOP    = 6'd0,
        OP_ALU    = 6'd1,
        OP_ALUI   = 6'd2,
        OP_LOAD   = 6'd3,
        OP_STORE  = 6'd4,
        OP_BRANCH = 6'd5
    } opcode_e;

    // Only register-register forms read the rs2 field; the rest reuse it as immediate bits.
    function automatic logic rs2_used(input logic [5:0] opc);
        return (opc == OP_ALU) || (opc == OP_STORE) || (opc == OP_BRANCH);
    endfunction

endpackage

// File: rtl/kamacore_stage_id_if.sv
// Decode-stage bus: fetch input, flush, write-back port and the ID/EX register outputs.
interface kamacore_stage_id_if #(
    parameter int unsigned CPU_WIDTH = kamacore_pkg::CPU_WIDTH,
    parameter int unsigned REG_IDX_W = kamacore_pkg::REG_IDX_W
);
    logic [CPU_WIDTH-1:0] if_instr;
    logic                 if_valid;
    logic                 flush;
    logic                 stall;
    logic                 wb_we;
    logic [REG_IDX_W-1:0] wb_rd;
    logic [CPU_WIDTH-1:0] wb_data;
    logic                 ex_valid;
    logic [5:0]           ex_opcode;
    logic [REG_IDX_W-1:0] ex_rd;
    logic [CPU_WIDTH-1:0] ex_rs1_val;
    logic [CPU_WIDTH-1:0] ex_rs2_val;
    logic [CPU_WIDTH-1:0] ex_imm;
    logic                 ex_is_load;
    logic                 ex_illegal;

    modport master (
        output if_instr, if_valid, flush, wb_we, wb_rd, wb_data,
        input  stall, ex_valid, ex_opcode, ex_rd, ex_rs1_val, ex_rs2_val,
               ex_imm, ex_is_load, ex_illegal
    );

    modport slave (
        input  if_instr, if_valid, flush, wb_we, wb_rd, wb_data,
        output stall, ex_valid, ex_opcode, ex_rd, ex_rs1_val, ex_rs2_val,
               ex_imm, ex_is_load, ex_illegal
    );
endinterface

// File: rtl/kamacore_regfile.sv
// 2R1W register file with x0 hardwired to zero, async clear and write-through reads.
module kamacore_regfile #(
    parameter int unsigned DATA_W    = kamacore_pkg::CPU_WIDTH,
    parameter int unsigned REG_COUNT = kamacore_pkg::REG_COUNT,
    parameter int unsigned IDX_W     = kamacore_pkg::REG_IDX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  wa_i,
    input  logic [DATA_W-1:0] wd_i,
    input  logic [IDX_W-1:0]  ra1_i,
    output logic [DATA_W-1:0] rd1_o,
    input  logic [IDX_W-1:0]  ra2_i,
    output logic [DATA_W-1:0] rd2_o
);

    logic [DATA_W-1:0] regs_q [REG_COUNT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q <= '{default: '0};
        end else if (we_i && (wa_i != '0)) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    // A same-cycle write wins over the stored value so decode never sees stale data.
    always_comb begin
        rd1_o = '0;
        rd2_o = '0;
        if (ra1_i != '0) begin
            rd1_o = (we_i && (wa_i == ra1_i)) ? wd_i : regs_q[ra1_i];
        end
        if (ra2_i != '0) begin
            rd2_o = (we_i && (wa_i == ra2_i)) ? wd_i : regs_q[ra2_i];
        end
    end

endmodule

// File: rtl/kamacore_stage_id.sv
// Instruction decode stage: field extraction, register read, load-use stall and ID/EX register.
module kamacore_stage_id #(
    parameter int unsigned CPU_WIDTH = kamacore_pkg::CPU_WIDTH,
    parameter int unsigned REG_COUNT = kamacore_pkg::REG_COUNT
) (
    input  logic                  clk,
    input  logic                  rst,
    kamacore_stage_id_if.slave    id
);
    import kamacore_pkg::*;

    logic [CPU_WIDTH-1:0] instr;
    logic [5:0]           opc;
    logic [REG_IDX_W-1:0] rd, rs1, rs2;
    logic [15:0]          imm;
    logic                 legal, uses_rs2, stall;
    logic [CPU_WIDTH-1:0] rs1_val, rs2_val;

    logic                 ex_valid_q, ex_is_load_q, ex_illegal_q;
    logic [5:0]           ex_opcode_q;
    logic [REG_IDX_W-1:0] ex_rd_q;
    logic [CPU_WIDTH-1:0] ex_rs1_val_q, ex_rs2_val_q, ex_imm_q;

    assign instr    = id.if_instr;
    assign opc      = instr[OPC_MSB:OPC_LSB];
    assign rd       = instr[RD_MSB:RD_LSB];
    assign rs1      = instr[RS1_MSB:RS1_LSB];
    assign rs2      = instr[RS2_MSB:RS2_LSB];
    assign imm      = instr[IMM_MSB:IMM_LSB];
    assign legal    = (opc <= OP_BRANCH);
    assign uses_rs2 = rs2_used(opc);

    kamacore_regfile #(
        .DATA_W    (CPU_WIDTH),
        .REG_COUNT (REG_COUNT),
        .IDX_W     (REG_IDX_W)
    ) u_regfile (
        .clk   (clk),
        .rst   (rst),
        .we_i  (id.wb_we),
        .wa_i  (id.wb_rd),
        .wd_i  (id.wb_data),
        .ra1_i (rs1),
        .rd1_o (rs1_val),
        .ra2_i (rs2),
        .rd2_o (rs2_val)
    );

    // Flush drops the consumer, so it also cancels any pending load-use stall.
    assign stall = ex_valid_q && ex_is_load_q && (ex_rd_q != '0)
                   && ((ex_rd_q == rs1) || (uses_rs2 && (ex_rd_q == rs2)))
                   && id.if_valid && !id.flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_q   <= 1'b0;
            ex_illegal_q <= 1'b0;
            ex_is_load_q <= 1'b0;
            ex_opcode_q  <= '0;
            ex_rd_q      <= '0;
            ex_rs1_val_q <= '0;
            ex_rs2_val_q <= '0;
            ex_imm_q     <= '0;
        end else if (id.flush || stall) begin
            ex_valid_q   <= 1'b0;
            ex_illegal_q <= 1'b0;
            ex_is_load_q <= 1'b0;
            ex_opcode_q  <= '0;
            ex_rd_q      <= '0;
            ex_rs1_val_q <= '0;
            ex_rs2_val_q <= '0;
            ex_imm_q     <= '0;
        end else begin
            ex_valid_q   <= id.if_valid && legal && (opc != OP_NOP);
            ex_illegal_q <= id.if_valid && !legal;
            ex_is_load_q <= (opc == OP_LOAD);
            ex_opcode_q  <= opc;
            ex_rd_q      <= rd;
            ex_rs1_val_q <= rs1_val;
            ex_rs2_val_q <= rs2_val;
            ex_imm_q     <= {{(CPU_WIDTH-16){imm[15]}}, imm};
        end
    end

    assign id.stall      = stall;
    assign id.ex_valid   = ex_valid_q;
    assign id.ex_illegal = ex_illegal_q;
    assign id.ex_is_load = ex_is_load_q;
    assign id.ex_opcode  = ex_opcode_q;
    assign id.ex_rd      = ex_rd_q;
    assign id.ex_rs1_val = ex_rs1_val_q;
    assign id.ex_rs2_val = ex_rs2_val_q;
    assign id.ex_imm     = ex_imm_q;

endmodule
